fp_result_collector: RTL
========================

// Module: fp_result_collector
// PURPOSE
//  Downstream companion of the non-stallable, fixed-latency float units (mulFN, addFN, ...).
//  Captures each {out, exceptionFlags} on the unit's done pulse into a small FIFO.
//  Re-presents results on a valid/ready port and accumulates sticky IEEE exception flags.
//  Issues credits upstream so the producer never launches an op whose result cannot be stored.
// PARAMETERS
//  WIDTH  32  result width (expWidth + sigWidth of the attached unit)
//  DEPTH  4   FIFO entries = total credits; power of two, >= 2
// PORTS
//  clk           in   1      clock
//  reset         in   1      synchronous, active-high
//  issue_val     in   1      producer launches an op into the FP unit this cycle (val to unit)
//  issue_ok      out  1      credit available; producer must not assert issue_val when low
//  fu_done       in   1      FP unit result valid this cycle
//  fu_out        in   WIDTH  FP unit result, sampled only when fu_done=1
//  fu_flags      in   5      FP unit exceptionFlags {NV,DZ,OF,UF,NX}, sampled with fu_out
//  res_valid     out  1      FIFO head valid
//  res_ready     in   1      consumer accepts head
//  res_data      out  WIDTH  FIFO head result
//  res_flags     out  5      FIFO head flags
//  sticky_flags  out  5      OR of flags of every accepted (pushed) result since reset/clear
//  clear_sticky  in   1      clears sticky_flags (a push in the same cycle still ORs in)
//  err           out  2      sticky {spurious_done, overflow}; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except issue_ok=1; FIFO empty; in_flight=0. Reset mid-op drops everything.
//  - issue = issue_val & issue_ok; push = fu_done; pop = res_valid & res_ready.
//  - in_flight counter, width $clog2(DEPTH+1): +1 on issue, -1 on fu_done, net 0 when both.
//  - count = FIFO occupancy, same width: +1 on push (if not full), -1 on pop, net 0 when both.
//  - issue_ok = (in_flight + count) < DEPTH, from registered state only.
//    A same-cycle pop does not return credit until the next cycle.
//  - Consequence: in_flight + count <= DEPTH always, so a legal push never finds the FIFO full.
//  - Push when full and no pop: entry dropped, err[0] set.
//    Full + push + pop in the same cycle is legal: the entry is stored and the head is popped.
//  - fu_done while in_flight==0 with no same-cycle issue: err[1] set.
//    The entry is still pushed if there is space; in_flight saturates at 0.
//  - issue_val while issue_ok=0 is ignored: no count change and no error.
//  - res_data/res_flags registered from the FIFO head; latency fu_done -> res_valid = 1 cycle.
//  - Pop from an empty FIFO is impossible (res_valid=0); res_data holds its last value when empty.
//  - sticky_flags next = (clear_sticky ? 0 : sticky_flags) | (push_accepted ? fu_flags : 0).
//  - Read/write pointers are $clog2(DEPTH) bits, wrap naturally.
//    Full/empty are derived from count, not from pointer compare.
//  - Ordering: results leave in fu_done order. The unit is in-order, so this is issue order.
// STRUCTURE
//  - float_pkg (shared): FLAG_NV=4, FLAG_DZ=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0 indices;
//    typedef fp_flags_t logic[4:0]; floatControlWidth lives here too.
//  - One sub-module: fp_result_fifo #(WIDTH+5, DEPTH). Synchronous FIFO with push/pop/count,
//    no internal overflow protection.
//  - Top level holds the credit counter, sticky flags, error bits and push/pop gating.
// TESTING
//  - Reset: hold reset 2 cycles -> issue_ok=1, res_valid=0, sticky_flags=0, err=0.
//  - Single op: issue at t0, fu_done at t0+4 with out=32'h40490FDB, flags=5'b00001
//    -> res_valid at t0+5 with that data; sticky_flags=5'b00001.
//  - Credit stall, DEPTH=4, res_ready=0: 4 back-to-back issues -> issue_ok low from the 4th issue+1.
//    After 4 dones, count=4. One pop -> issue_ok=1 the next cycle.
//  - Simultaneous: full FIFO, pop + fu_done same cycle -> count stays 4, order preserved, err=0.
//  - Errors: fu_done with nothing in flight -> err[1]=1. Forced push into full FIFO -> err[0]=1,
//    entry dropped, FIFO contents unchanged.
//  - Sticky: results with flags 5'b10000 then 5'b00100 -> sticky 5'b10100.
//    clear_sticky coincident with a push of 5'b00001 -> sticky 5'b00001.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the float units and their companions.
package float_pkg;

  // Bit positions inside exceptionFlags {NV,DZ,OF,UF,NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam int unsigned NUM_FLAGS = 5;

  localparam int unsigned floatControlWidth = 1;

  typedef logic [NUM_FLAGS-1:0] fp_flags_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Synchronous FIFO with a registered head output. The caller guarantees that it
// never pushes into a full FIFO without a same-cycle pop, and never pops when empty.
module fp_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Pointer/count next state and the look-ahead head for the output register
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head holds its last value once the FIFO drains; a freshly written slot that
    // becomes the head is forwarded straight from wdata.
    rdata_d = rdata_q;
    if (count_d != '0) begin
      rdata_d = (push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Control state and head register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;

endmodule

// File: rtl/fp_result_collector.sv
// Collects results of a fixed-latency, non-stallable float unit into a FIFO,
// re-presents them on valid/ready, tracks sticky IEEE flags and hands out credits
// so the producer never launches an op whose result would have nowhere to go.
module fp_result_collector
  import float_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_val,
  output logic             issue_ok,
  input  logic             fu_done,
  input  logic [WIDTH-1:0] fu_out,
  input  fp_flags_t        fu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output fp_flags_t        res_flags,
  output fp_flags_t        sticky_flags,
  input  logic             clear_sticky,
  output logic [1:0]       err
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = WIDTH + NUM_FLAGS;

  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credits_used;
  fp_flags_t        sticky_q, sticky_d;
  logic [1:0]       err_q, err_d;

  logic issue, pop, full, push_acc, spurious, overflow;

  // Credit check uses registered state only; a pop this cycle frees a credit next cycle
  always_comb begin
    credits_used = {1'b0, in_flight_q} + {1'b0, count};
    issue_ok     = credits_used < (CNT_W + 1)'(DEPTH);
    res_valid    = count != '0;
    full         = count == CNT_W'(DEPTH);
    issue        = issue_val && issue_ok;
    pop          = res_valid && res_ready;
    overflow     = fu_done && full && !pop;
    push_acc     = fu_done && !overflow;
    spurious     = fu_done && (in_flight_q == '0) && !issue;
  end

  // Next state for in-flight count, sticky flags and error bits
  always_comb begin
    in_flight_d = in_flight_q;
    if (issue && !fu_done) begin
      in_flight_d = in_flight_q + CNT_W'(1);
    end else if (!issue && fu_done && (in_flight_q != '0)) begin
      in_flight_d = in_flight_q - CNT_W'(1);
    end
    sticky_d = (clear_sticky ? '0 : sticky_q) | (push_acc ? fu_flags : '0);
    err_d    = err_q | {spurious, overflow};
  end

  // Collector state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight_q <= '0;
      sticky_q    <= '0;
      err_q       <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      sticky_q    <= sticky_d;
      err_q       <= err_d;
    end
  end

  fp_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_acc),
    .wdata ({fu_out, fu_flags}),
    .pop   (pop),
    .rdata ({res_data, res_flags}),
    .count (count)
  );

  assign sticky_flags = sticky_q;
  assign err          = err_q;

endmodule
